// File: rtl/lms_ctr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lms_ctr_pkg
//  Purpose  : Shared definitions for the LMS control GPIO / power-up
//             sequencer: register addresses, CTRL bit positions and the
//             sequencer state encoding (visible to software at CTRL b6:4).
//  Revision : 1.0  initial release
// ============================================================================
package lms_ctr_pkg;

    // Word addresses of the slave register map
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_HOLD   = 3'd2;
    localparam logic [2:0] ADDR_SETTLE = 3'd3;
    localparam logic [2:0] ADDR_SET    = 3'd4;
    localparam logic [2:0] ADDR_CLR    = 3'd5;

    // CTRL write fields
    localparam int CTRL_START  = 0;
    localparam int CTRL_TGT_LO = 1;
    localparam int CTRL_TGT_HI = 3;
    localparam int CTRL_CLEAR  = 8;
    localparam int CTRL_IRQ_EN = 9;

    // CTRL read fields
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERR   = 2;
    localparam int STAT_ST_LO = 4;
    localparam int STAT_ST_HI = 6;

    // Sequencer states; the encoding is software visible
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        SETTLE  = 3'd4,
        APPLY   = 3'd5
    } seq_state_t;

endpackage : lms_ctr_pkg
`default_nettype wire

// File: rtl/lms_ctr_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : lms_ctr_delay_cnt
//  Purpose  : Loadable down-counter shared by the HOLD and SETTLE phases.
//             o_expired is high once the count has reached 1 (or 0), so a
//             load value of 0 or 1 both give a single-cycle phase.
//  Revision : 1.0  initial release
// ============================================================================
module lms_ctr_delay_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over counting; the count saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt <= CNT_W'(1));

endmodule : lms_ctr_delay_cnt
`default_nettype wire

// File: rtl/lms_ctr_gpio_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lms_ctr_gpio_seq
//  Purpose  : Avalon-MM slave owning the LMS7002 control GPIO
//             (b0 LMS_RESET active-low, b1 core LDO, b2 RXEN, b3 TXEN) with a
//             power-up sequencer: reset pulse, hold, release, settle, apply.
//             CPU writes and the sequencer share one output register; while
//             the sequencer is busy, CPU pin writes are dropped and flag ERR.
//  Option   : LMS_CTR_SEQ_AUTOSTART_EN - run the sequence once, straight out
//             of reset, with TARGET = RST_VAL[3:1].
//  Revision : 1.0  initial release
// ============================================================================
module lms_ctr_gpio_seq
    import lms_ctr_pkg::*;
#(
    parameter int                DATA_W     = 4,
    parameter logic [DATA_W-1:0] RST_VAL    = DATA_W'(4'h3),
    parameter int                CNT_W      = 16,
    parameter logic [CNT_W-1:0]  HOLD_DEF   = CNT_W'(100),
    parameter logic [CNT_W-1:0]  SETTLE_DEF = CNT_W'(1000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              irq
);

    seq_state_t        r_state;
    logic [DATA_W-1:0] r_out;
    logic              r_done;
    logic              r_err;
    logic              r_irq_en;
    logic [2:0]        r_target;
    logic [CNT_W-1:0]  r_hold;
    logic [CNT_W-1:0]  r_settle;

    logic              w_wr;
    logic              w_wr_data;
    logic              w_wr_ctrl;
    logic              w_wr_hold;
    logic              w_wr_settle;
    logic              w_wr_set;
    logic              w_wr_clr;
    logic              w_busy;
    logic              w_cpu_start;
    logic              w_start;
    logic [2:0]        w_start_target;
    logic              w_bus_violation;
    logic              w_cnt_load;
    logic              w_cnt_en;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_expired;
    logic [31:0]       w_rd;
    logic              w_unused_wd;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_wr        = chipselect & ~write_n;
    assign w_wr_data   = w_wr & (address == ADDR_DATA);
    assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
    assign w_wr_hold   = w_wr & (address == ADDR_HOLD);
    assign w_wr_settle = w_wr & (address == ADDR_SETTLE);
    assign w_wr_set    = w_wr & (address == ADDR_SET);
    assign w_wr_clr    = w_wr & (address == ADDR_CLR);

    assign w_busy      = (r_state != IDLE);
    assign w_cpu_start = w_wr_ctrl & writedata[CTRL_START];

    // Anything that would move the pins or restart the sequence mid-flight
    assign w_bus_violation = w_busy & (w_cpu_start | w_wr_data | w_wr_set | w_wr_clr);

    // Only a few writedata bits are decoded; fold the rest away
    assign w_unused_wd = ^writedata;

`ifdef LMS_CTR_SEQ_AUTOSTART_EN
    logic r_auto_pend;

    // One-shot start request that fires on the first cycle out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_auto_pend <= 1'b1;
        end else begin
            r_auto_pend <= 1'b0;
        end
    end

    assign w_start        = r_auto_pend | w_cpu_start;
    assign w_start_target = r_auto_pend ? RST_VAL[3:1]
                                        : writedata[CTRL_TGT_HI:CTRL_TGT_LO];
`else
    assign w_start        = w_cpu_start;
    assign w_start_target = writedata[CTRL_TGT_HI:CTRL_TGT_LO];
`endif

    // ------------------------------------------------------------------
    // Shared phase counter: loaded in ASSERT (HOLD) and RELEASE (SETTLE)
    // ------------------------------------------------------------------
    assign w_cnt_load = (r_state == ASSERT) | (r_state == RELEASE);
    assign w_cnt_en   = (r_state == HOLD)   | (r_state == SETTLE);
    assign w_cnt_val  = (r_state == ASSERT) ? r_hold : r_settle;

    lms_ctr_delay_cnt #(
        .CNT_W      (CNT_W)
    ) u_delay_cnt (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_en       (w_cnt_en),
        .o_expired  (w_cnt_expired)
    );

    // ------------------------------------------------------------------
    // Register file, pin register and sequencer; statements are ordered so
    // that a clear is overridden by an error or DONE raised in the same cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_out    <= RST_VAL;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_irq_en <= 1'b0;
            r_target <= 3'd0;
            r_hold   <= HOLD_DEF;
            r_settle <= SETTLE_DEF;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= writedata[CTRL_IRQ_EN];
                if (writedata[CTRL_CLEAR]) begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                end
            end

            // Timing registers are always writable; the counter samples them at load
            if (w_wr_hold) begin
                r_hold <= writedata[CNT_W-1:0];
            end
            if (w_wr_settle) begin
                r_settle <= writedata[CNT_W-1:0];
            end

            if (w_bus_violation) begin
                r_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_target <= w_start_target;
                        r_state  <= ASSERT;
                    end else if (w_wr_data) begin
                        r_out <= writedata[DATA_W-1:0];
                    end else if (w_wr_set) begin
                        r_out <= r_out | writedata[DATA_W-1:0];
                    end else if (w_wr_clr) begin
                        r_out <= r_out & ~writedata[DATA_W-1:0];
                    end
                end
                ASSERT: begin
                    r_out[0] <= 1'b0;
                    r_state  <= HOLD;
                end
                HOLD: begin
                    if (w_cnt_expired) begin
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_out[0] <= 1'b1;
                    r_state  <= SETTLE;
                end
                SETTLE: begin
                    if (w_cnt_expired) begin
                        r_state <= APPLY;
                    end
                end
                APPLY: begin
                    r_out[3:1] <= r_target;
                    r_done     <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Zero-wait-state read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_rd = '0;
        case (address)
            ADDR_DATA: begin
                w_rd[DATA_W-1:0] = r_out;
            end
            ADDR_CTRL: begin
                w_rd[STAT_BUSY]              = w_busy;
                w_rd[STAT_DONE]              = r_done;
                w_rd[STAT_ERR]               = r_err;
                w_rd[STAT_ST_HI:STAT_ST_LO]  = r_state;
                w_rd[CTRL_IRQ_EN]            = r_irq_en;
            end
            ADDR_HOLD: begin
                w_rd[CNT_W-1:0] = r_hold;
            end
            ADDR_SETTLE: begin
                w_rd[CNT_W-1:0] = r_settle;
            end
            default: begin
                w_rd = '0;
            end
        endcase
    end

    assign readdata = w_rd;
    assign out_port = r_out;
    assign irq      = r_done & r_irq_en;

endmodule : lms_ctr_gpio_seq
`default_nettype wire
